// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//   Iterative multiply / divide unit that owns the architectural HI/LO pair.
//   Multiplies use a shift-add datapath that retires one multiplier bit per
//   cycle. Divides use a restoring datapath that retires one quotient bit per
//   cycle. MADD/MSUB fold the signed product into the current HI/LO value.
//   A start/busy/done handshake lets the hazard unit stall EX while an
//   operation is in flight.
//
// Ports
//   Clk     : system clock, rising edge
//   Reset   : synchronous, active-high reset
//   Start   : operation request, only looked at while Busy=0
//   Op      : 000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//             100 MADD, 101 MSUB, 110 MTHI, 111 MTLO
//   A       : operand A (rs, dividend)
//   B       : operand B (rt, divisor)
//   Busy    : multiply/divide in progress
//   Done    : one-cycle pulse, Hi/Lo were just updated
//   Hi, Lo  : architectural HI/LO registers
//   DivZero : last multiply/divide was a divide by zero
// -----------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             DivZero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MSUB  = 3'b101;
  localparam logic [2:0] OP_MTHI  = 3'b110;
  localparam logic [2:0] OP_MTLO  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } state_t;

  // Two's complement negate of a WIDTH-bit value.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return (~v) + WIDTH'(1);
  endfunction

  // Two's complement negate of a 2*WIDTH-bit value.
  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return (~v) + (2*WIDTH)'(1);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_move(input logic [2:0] op);
    return (op == OP_MTHI) || (op == OP_MTLO);
  endfunction

  function automatic logic is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  state_t             state_r, state_s;
  logic [CW-1:0]      cnt_r;
  logic [2:0]         op_r;
  logic [WIDTH-1:0]   a_r;        // original dividend, returned in Hi on divide by zero
  logic [WIDTH-1:0]   opd_r;      // multiplicand magnitude or divisor magnitude
  logic [2*WIDTH-1:0] acc_r;      // mult: {partial, multiplier}; div: {remainder, quotient}
  logic               neg_p_r;    // product / quotient must be negated at FIX
  logic               neg_r_r;    // remainder must be negated at FIX
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               divzero_r;

  logic               sign_a_s, sign_b_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s;
  logic [WIDTH-1:0]   start_opd_s;
  logic [2*WIDTH-1:0] start_acc_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_shift_s;
  logic [WIDTH:0]     div_diff_s;
  logic [2*WIDTH-1:0] acc_step_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] hilo_fix_s;
  logic               divzero_fix_s;

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (Start && !is_move(Op)) begin
          state_s = S_RUN;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (cnt_r == CW'(1)) begin
          state_s = S_FIX;
        end else begin
          state_s = S_RUN;
        end
      end
      S_FIX:   state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Operand conditioning at the start edge: magnitudes and the datapath seed.
  always_comb begin
    sign_a_s = is_signed(Op) && A[WIDTH-1];
    sign_b_s = is_signed(Op) && B[WIDTH-1];
    mag_a_s  = sign_a_s ? neg_w(A) : A;
    mag_b_s  = sign_b_s ? neg_w(B) : B;
    if (is_div(Op)) begin
      start_opd_s = mag_b_s;
      start_acc_s = {{WIDTH{1'b0}}, mag_a_s};
    end else begin
      start_opd_s = mag_a_s;
      start_acc_s = {{WIDTH{1'b0}}, mag_b_s};
    end
  end

  // One shift-add or restoring-divide step.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                  (acc_r[0] ? {1'b0, opd_r} : {(WIDTH+1){1'b0}});
    div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, opd_r};
    if (is_div(op_r)) begin
      // A set top bit on the difference means the trial subtraction went
      // negative, so the shifted remainder is restored and a 0 goes in.
      if (div_diff_s[WIDTH]) begin
        acc_step_s = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
      end else begin
        acc_step_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_step_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    end
  end

  // Sign correction and HI/LO result selection used at FIX.
  always_comb begin
    prod_s        = neg_p_r ? neg_2w(acc_r) : acc_r;
    divzero_fix_s = is_div(op_r) && (opd_r == {WIDTH{1'b0}});
    case (op_r)
      OP_MULT, OP_MULTU: hilo_fix_s = prod_s;
      OP_MADD:           hilo_fix_s = {hi_r, lo_r} + prod_s;
      OP_MSUB:           hilo_fix_s = {hi_r, lo_r} - prod_s;
      OP_DIV, OP_DIVU: begin
        if (divzero_fix_s) begin
          hilo_fix_s = {a_r, {WIDTH{1'b1}}};
        end else begin
          hilo_fix_s[2*WIDTH-1:WIDTH] = neg_r_r ? neg_w(acc_r[2*WIDTH-1:WIDTH])
                                                : acc_r[2*WIDTH-1:WIDTH];
          hilo_fix_s[WIDTH-1:0]       = neg_p_r ? neg_w(acc_r[WIDTH-1:0])
                                                : acc_r[WIDTH-1:0];
        end
      end
      default:           hilo_fix_s = {hi_r, lo_r};
    endcase
  end

  // Datapath, HI/LO and handshake registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_r     <= {CW{1'b0}};
      op_r      <= 3'b000;
      a_r       <= {WIDTH{1'b0}};
      opd_r     <= {WIDTH{1'b0}};
      acc_r     <= {(2*WIDTH){1'b0}};
      neg_p_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
      divzero_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (Start) begin
            if (Op == OP_MTHI) begin
              hi_r   <= A;
              done_r <= 1'b1;
            end else if (Op == OP_MTLO) begin
              lo_r   <= A;
              done_r <= 1'b1;
            end else begin
              op_r    <= Op;
              a_r     <= A;
              opd_r   <= start_opd_s;
              acc_r   <= start_acc_s;
              neg_p_r <= sign_a_s ^ sign_b_s;
              neg_r_r <= sign_a_s;
              cnt_r   <= CW'(WIDTH);
              busy_r  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          acc_r <= acc_step_s;
          cnt_r <= cnt_r - CW'(1);
        end
        S_FIX: begin
          hi_r      <= hilo_fix_s[2*WIDTH-1:WIDTH];
          lo_r      <= hilo_fix_s[WIDTH-1:0];
          divzero_r <= divzero_fix_s;
          done_r    <= 1'b1;
          busy_r    <= 1'b0;
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign Busy    = busy_r;
  assign Done    = done_r;
  assign Hi      = hi_r;
  assign Lo      = lo_r;
  assign DivZero = divzero_r;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised iterative multiply/divide unit holding the architectural HI/LO pair for the MIPS datapath.
- Sits beside the single-cycle ALU in EX.
- Replaces the ALU's combinational multiply with a WIDTH-cycle shift-add multiplier and a restoring divider, plus multiply-accumulate.
- Uses a start/busy/done handshake that the hazard unit consumes to stall.

Parameters:
WIDTH, 32, operand and HI/LO register width; must be ≥ 4. Iteration counter is clog2(WIDTH+1) bits.

Ports:
Clk  input  1  system clock, rising-edge
Reset  input  1  synchronous, active-high reset
Start  input  1  request; sampled only when Busy=0
Op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD (signed), 101 MSUB (signed), 110 MTHI, 111 MTLO
A  input  WIDTH  operand A (rs; dividend)
B  input  WIDTH  operand B (rt; divisor)
Busy  output  1  operation in progress
Done  output  1  one-cycle pulse: Hi/Lo just updated
Hi  output  WIDTH  HI register
Lo  output  WIDTH  LO register
DivZero  output  1  sticky per op: last divide had B=0

Behaviour:
- Interface: one clock (Clk); Reset is synchronous and active-high.
- Reset (any cycle, including mid-operation): state IDLE; Busy=0, Done=0, Hi=0, Lo=0, DivZero=0. Any in-flight operation is discarded.
- States: IDLE, RUN, FIX.
- IDLE, Start=1, Op=MTHI/MTLO:
  - Hi (or Lo) ← A at that edge.
  - Done=1 next cycle; Busy stays 0.
  - DivZero unchanged.
- IDLE, Start=1, Op=MULT..MSUB (edge E0):
  - Latch A, B and Op.
  - Signed ops convert operands to magnitudes and record the result sign(s).
  - Counter ← WIDTH; state ← RUN; Busy=1 from the cycle after E0.
- RUN: one iteration per edge, counter decrements; at counter 1→0, state ← FIX.
  - Multiply: shift-add, 1 multiplier bit per cycle, into a 2*WIDTH accumulator.
  - Divide: restoring, 1 quotient bit per cycle.
- FIX (edge E0+WIDTH+1): apply sign correction, write Hi/Lo, Done=1 for the following cycle, Busy=0, state ← IDLE.
  - Total latency: WIDTH+1 edges from the Start edge to the Hi/Lo update.
- Multiply results:
  - MULT/MULTU: {Hi,Lo} = full 2*WIDTH product.
  - MADD: {Hi,Lo} ← {Hi,Lo} + signed product, mod 2^(2*WIDTH).
  - MSUB: {Hi,Lo} ← {Hi,Lo} − signed product, mod 2^(2*WIDTH).
  - MADD/MSUB use the Hi/Lo value present at FIX.
- Divide results:
  - Lo = quotient, Hi = remainder.
  - Signed quotient truncates toward zero; remainder takes the dividend's sign.
  - Signed overflow (A = most negative, B = −1): Lo = most negative, Hi = 0, no flag.
- Divide by zero (B=0, DIV or DIVU):
  - Still takes full latency.
  - Result: Lo = all ones, Hi = A (original, unmodified), DivZero=1.
  - DivZero is cleared at the FIX of any non-divide-by-zero multiply/divide.
- Start while Busy=1: ignored, no queueing. Op/A/B changes while busy have no effect.
- Start in the Done cycle (Busy=0): accepted normally. Back-to-back throughput is one op per WIDTH+2 cycles.
- Hi/Lo are stable except at MTHI/MTLO edges, FIX edges, or Reset.
- Done is never high for two consecutive cycles from a single request.

Test Plan:
1. Reset, then MULT, A=−3 (0xFFFFFFFD), B=7 -> Busy for 33 cycles; Done pulse exactly 33 edges after Start; Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
2. MULTU, A=0xFFFFFFFF, B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001. Then MADD, A=2, B=3 -> Hi=0xFFFFFFFE, Lo=0x00000007. Then MSUB, A=1, B=8 -> Lo=0xFFFFFFFF, Hi=0xFFFFFFFD.
3. DIV −7/2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU 100/7 -> Lo=14, Hi=2. DIV 0x80000000/−1 -> Lo=0x80000000, Hi=0, DivZero=0.
4. DIVU, A=0x1234, B=0 -> Lo=0xFFFFFFFF, Hi=0x1234, DivZero=1. Next MULT 2*2 -> DivZero=0, Lo=4.
5. Start a MULT; assert Start with a different Op at cycle 5 -> ignored, original result only. Assert Reset at cycle 10 -> Busy=0, Hi=Lo=0 next cycle, no Done.
6. MTHI, A=0xAAAA5555 -> Hi updated at that edge, Done next cycle, Busy never 1. Repeat tests 1 and 3 with WIDTH=8 (latency 9 edges; 0x80/0xFF -> Lo=0x80, Hi=0).
